// File: rtl/axi_wr_arbiter_pkg.sv
// Shared AXI widths, response codes and arbiter FSM states
// for the cache write-back AXI arbiter.
package axi_wr_arbiter_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 64;
  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ID         = 2;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

endpackage

// File: rtl/axi_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr.
// The pointer itself lives in the parent.
module axi_wr_arbiter_rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write port between
// single-beat requesters, with B credit tracking and routing.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter  int N_REQ           = 2,
  parameter  int ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter  int DATA_WIDTH      = AXI_DATA_WIDTH,
  parameter  int ID_WIDTH        = AXI_ID_WIDTH,
  parameter  int ID_BASE         = AXI_ID,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [N_REQ-1:0]            done_o,
  output logic [N_REQ-1:0]            err_o,
  output logic [ID_WIDTH-1:0]         awid_o,
  output logic [ADDR_WIDTH-1:0]       awaddr_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [ID_WIDTH-1:0]         wid_o,
  output logic [DATA_WIDTH-1:0]       wdata_o,
  output logic                        wlast_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,
  input  logic [ID_WIDTH-1:0]         bid_i,
  input  logic [1:0]                  bresp_i,
  input  logic                        bvalid_i,
  output logic                        bready_o,
  output logic [OW-1:0]               outstanding_o
);

  state_t                  state, state_n;
  logic [PW-1:0]           rr_ptr, ptr_n;
  logic                    aw_done, w_done;
  logic [OW-1:0]           outstanding;
  logic [N_REQ-1:0]        done_q, err_q, done_n, err_n;
  logic                    bready_q;
  logic [ID_WIDTH-1:0]     awid_q, sel_id;
  logic [ADDR_WIDTH-1:0]   awaddr_q, sel_addr;
  logic [DATA_WIDTH-1:0]   wdata_q, sel_data;
  logic [N_REQ-1:0]        grant;
  logic                    can_grant, inc, dec;
  logic                    aw_hs, w_hs, b_hs;

  assign can_grant = !rst && (state == S_IDLE)
                  && (outstanding < OW'(MAX_OUTSTANDING));

  axi_wr_arbiter_rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid_i),
    .en    (can_grant),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign awvalid_o = (state == S_SEND) && !aw_done;
  assign wvalid_o  = (state == S_SEND) && !w_done;
  assign aw_hs     = awvalid_o && awready_i;
  assign w_hs      = wvalid_o && wready_i;
  assign b_hs      = bvalid_i && bready_q;
  assign inc       = |grant;
  assign dec       = b_hs && (outstanding != '0);

  assign req_ready_o   = grant;
  assign awid_o        = awid_q;
  assign wid_o         = awid_q;
  assign awaddr_o      = awaddr_q;
  assign wdata_o       = wdata_q;
  assign wlast_o       = 1'b1;
  assign bready_o      = bready_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign outstanding_o = outstanding;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_id   = '0;
    ptr_n    = rr_ptr;
    done_n   = '0;
    err_n    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_id   = ID_WIDTH'(ID_BASE + k);
        ptr_n    = PW'((k + 1) % N_REQ);
      end
      // IDs wrap modulo 2^ID_WIDTH, so out-of-range bids match nobody
      done_n[k] = b_hs && (bid_i == ID_WIDTH'(ID_BASE + k));
      err_n[k]  = done_n[k] && (bresp_i != AXI_RESP_OKAY);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (inc) state_n = S_SEND;
      S_SEND: if ((aw_done || aw_hs) && (w_done || w_hs))
                state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      outstanding <= '0;
      done_q      <= '0;
      err_q       <= '0;
      bready_q    <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= ptr_n;
      bready_q <= 1'b1;
      done_q   <= done_n;
      err_q    <= err_n;
      if (state_n == S_IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if (inc && !dec)
        outstanding <= outstanding + OW'(1);
      else if (dec && !inc)
        outstanding <= outstanding - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (inc) begin
      awid_q   <= sel_id;
      awaddr_q <= sel_addr;
      wdata_q  <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && b_hs) assert (outstanding != '0);
    if (!rst) assert (outstanding <= OW'(MAX_OUTSTANDING));
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter against a transaction-level
// model of grants, credits and B routing.
module tb_axi_wr_arbiter;

  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IW   = 4;
  localparam int IB   = 2;
  localparam int MAXO = 4;
  localparam int OW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready, done, err;
  logic [IW-1:0]   awid, wid, bid;
  logic [AW-1:0]   awaddr;
  logic [DW-1:0]   wdata;
  logic            awvalid, awready, wvalid, wready, wlast;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [OW-1:0]   outstanding;

  axi_wr_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .ID_BASE(IB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_ready_o(req_ready),
    .done_o(done), .err_o(err),
    .awid_o(awid), .awaddr_o(awaddr),
    .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wlast_o(wlast),
    .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid),
    .bready_o(bready), .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // model of the requesters and of the arbiter's contract
  logic [AW-1:0] qa[N][$];
  logic [DW-1:0] qd[N][$];
  logic [IW-1:0] ids[$];
  logic [AW-1:0] next_addr = 32'h1000;
  bit            m_busy, m_aw, m_w, m_bready;
  int            m_cred, m_ptr, m_cur;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_done, m_err;

  int p_push, p_aw, p_w, p_b, p_bad, p_er, p_rst;
  logic [N-1:0] mask;

  task automatic model_reset();
    m_busy   = 0; m_aw = 0; m_w = 0; m_bready = 0;
    m_cred   = 0; m_ptr = 0; m_cur = 0;
    m_done   = '0; m_err = '0;
    ids.delete();
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++)
      if (mask[k] && $urandom_range(99) < p_push) begin
        qa[k].push_back(next_addr);
        qd[k].push_back({$urandom, $urandom});
        next_addr += 32'h10;
      end
    for (int k = 0; k < N; k++) begin
      req_valid[k] = qa[k].size() != 0;
      req_addr[k*AW +: AW] =
        req_valid[k] ? qa[k][0] : AW'($urandom);
      req_data[k*DW +: DW] =
        req_valid[k] ? qd[k][0] : {$urandom, $urandom};
    end
    rst     = m_busy && m_aw && ($urandom_range(99) < p_rst);
    awready = $urandom_range(99) < p_aw;
    wready  = $urandom_range(99) < p_w;
    bvalid  = 1'b0;
    bid     = IW'($urandom);
    bresp   = 2'($urandom);
    if (!rst && m_bready && ids.size() > 0
        && $urandom_range(99) < p_b) begin
      bvalid = 1'b1;
      bid    = ids.pop_front();
      if ($urandom_range(99) < p_bad)
        bid = IW'(IB + N + $urandom_range(15 - N));
      bresp = ($urandom_range(99) < p_er) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic check_and_step();
    logic [N-1:0] exp_ready;
    logic [IW-1:0] k;
    int g;
    exp_ready = '0;
    g = -1;
    if (!m_busy && m_cred < MAXO)
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
    if (g >= 0) exp_ready[g] = 1'b1;

    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("awvalid", 64'(awvalid), 64'(m_busy && m_aw));
    chk("wvalid", 64'(wvalid), 64'(m_busy && m_w));
    chk("wlast", 64'(wlast), 64'(1));
    if (m_busy && m_aw) begin
      chk("awaddr", 64'(awaddr), 64'(m_addr));
      chk("awid", 64'(awid), 64'(IW'(IB + m_cur)));
    end
    if (m_busy && m_w) begin
      chk("wdata", 64'(wdata), 64'(m_data));
      chk("wid", 64'(wid), 64'(IW'(IB + m_cur)));
    end
    chk("bready", 64'(bready), 64'(m_bready));
    chk("outstanding", 64'(outstanding), 64'(m_cred));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));

    m_done = '0;
    m_err  = '0;
    if (bvalid) begin
      k = bid - IW'(IB);
      if (k < N) begin
        m_done[k] = 1'b1;
        m_err[k]  = bresp != 2'b00;
      end
      m_cred--;
    end
    if (m_busy) begin
      if (m_aw && awready) m_aw = 0;
      if (m_w && wready)   m_w  = 0;
      if (!m_aw && !m_w)   m_busy = 0;
    end else if (g >= 0) begin
      m_busy = 1; m_aw = 1; m_w = 1;
      m_cur  = g;
      m_addr = qa[g].pop_front();
      m_data = qd[g].pop_front();
      ids.push_back(IW'(IB + g));
      m_ptr  = (g + 1) % N;
      m_cred++;
    end
    m_bready = 1;
  endtask

  task automatic phase(int len, int push, int aw, int w,
                       int b, int bad, int er, int rs,
                       logic [N-1:0] m);
    p_push = push; p_aw = aw; p_w = w; p_b = b;
    p_bad = bad; p_er = er; p_rst = rs; mask = m;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      drive();
      #1;
      if (rst) begin
        chk("req_ready_rst", 64'(req_ready), 64'(0));
        model_reset();
      end else begin
        check_and_step();
      end
    end
  endtask

  initial begin
    model_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    req_data  = '0;
    awready   = 1'b1;
    wready    = 1'b1;
    bvalid    = 1'b0;
    bid       = '0;
    bresp     = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_awvalid", 64'(awvalid), 64'(0));
    chk("rst_wvalid", 64'(wvalid), 64'(0));
    chk("rst_bready", 64'(bready), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));

    phase(60,  30, 100, 100,  50,  0,  0,  0, 3'b001);
    phase(100, 100, 100, 100, 80,  0,  0,  0, 3'b111);
    phase(300, 50,  40,  40,  40, 10, 20,  0, 3'b111);
    phase(40,  100, 100, 100,  0,  0,  0,  0, 3'b111);
    phase(30,  0,   100, 100, 100, 0,  0,  0, 3'b111);
    phase(200, 60,  30,  30,  30, 10, 10, 15, 3'b111);
    phase(400, 30,  70,  30,  60, 20, 30,  0, 3'b110);
    phase(200, 80,  50,  50,  50,  5, 10,  3, 3'b111);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
